// File: rtl/msp430_clock_switch_ctrl.sv
// rtl/msp430_clock_switch_ctrl.sv - clock source switch sequencer ahead of the glitch-free clock mux
//
// Purpose:
//   Turns a software source request into a safe sequence for the clock mux.
//   It enables oscillator 1 and waits until the oscillator has been stable
//   for long enough. It then drives the mux selection and holds it while the
//   mux's two-stage handover completes. If oscillator 1 is lost, or fails to
//   start in time, it falls back to source 0 and raises a sticky fault.
//
// Optional feature (macro MSP430_CLKSW_OSC_KEEPALIVE_EN):
//   When the macro is defined, oscillator 1 stays enabled after a normal
//   return to source 0. A new request that finds the oscillator already
//   stable goes straight to the switch, without the start-up wait. Fault
//   returns still stop the oscillator.
//
// Parameters:
//   CNT_W          width of the wait and stabilisation counters
//   STAB_CYCLES    consecutive stable cycles required before switching (< 2**CNT_W)
//   TIMEOUT_CYCLES start-up budget in START1 (> STAB_CYCLES, < 2**CNT_W)
//   SWITCH_CYCLES  hold time after a selection edge (>= 4)
//
// Ports:
//   mclk        in   controller clock (always-running source 0 domain)
//   reset       in   asynchronous active-high reset
//   sel_req     in   requested source: 0 = clk_in0, 1 = clk_in1
//   osc1_ok     in   oscillator 1 valid, asynchronous to mclk
//   fault_clr   in   one-cycle pulse that clears fault
//   selection   out  clock mux selection input
//   osc1_enable out  oscillator 1 enable
//   sel_status  out  1 only while clk_in1 is fully in use (ON1)
//   busy        out  high in every state except IDLE0 and ON1
//   fault       out  sticky oscillator fault flag

module msp430_clock_switch_ctrl #(
  parameter int CNT_W          = 10,
  parameter int STAB_CYCLES    = 512,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SWITCH_CYCLES  = 8
) (
  input  logic mclk,
  input  logic reset,
  input  logic sel_req,
  input  logic osc1_ok,
  input  logic fault_clr,
  output logic selection,
  output logic osc1_enable,
  output logic sel_status,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE0   = 3'd0,
    START1  = 3'd1,
    SWITCH1 = 3'd2,
    ON1     = 3'd3,
    SWITCH0 = 3'd4,
    STOP1   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] STAB_LIM    = CNT_W'(STAB_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SWITCH_LIM  = CNT_W'(SWITCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] stab_nxt;
  logic [CNT_W-1:0] stab_inc;
  logic             osc1_meta;
  logic             osc1_ok_sync;
  logic             selection_nxt;
  logic             osc1_enable_nxt;
  logic             sel_status_nxt;
  logic             busy_nxt;
  logic             fault_nxt;
  logic             fault_set;

`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
  // Remembers whether SWITCH0 was entered because the oscillator was lost.
  // That decides whether the return path keeps the oscillator running.
  logic             loss_exit;
  logic             loss_exit_nxt;
`endif

  assign cnt_inc  = cnt + CNT_ONE;
  assign stab_inc = stab_cnt + CNT_ONE;

  // osc1_ok comes from the oscillator's own domain; two flops before use.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      osc1_meta    <= 1'b0;
      osc1_ok_sync <= 1'b0;
    end else begin
      osc1_meta    <= osc1_ok;
      osc1_ok_sync <= osc1_meta;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE0;
      cnt         <= '0;
      stab_cnt    <= '0;
      selection   <= 1'b0;
      osc1_enable <= 1'b0;
      sel_status  <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      stab_cnt    <= stab_nxt;
      selection   <= selection_nxt;
      osc1_enable <= osc1_enable_nxt;
      sel_status  <= sel_status_nxt;
      busy        <= busy_nxt;
      fault       <= fault_nxt;
    end
  end

`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      loss_exit <= 1'b0;
    end else begin
      loss_exit <= loss_exit_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    stab_nxt        = stab_cnt;
    selection_nxt   = selection;
    osc1_enable_nxt = osc1_enable;
    sel_status_nxt  = sel_status;
    fault_set       = 1'b0;
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
    loss_exit_nxt   = loss_exit;
`endif

    case (state)
      IDLE0: begin
        // A pending fault blocks new requests until software clears it.
        if (sel_req && !fault) begin
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
          if (osc1_ok_sync) begin
            // The oscillator was kept running and is still good.
            state_nxt       = SWITCH1;
            selection_nxt   = 1'b1;
            osc1_enable_nxt = 1'b1;
            cnt_nxt         = '0;
          end else begin
            state_nxt       = START1;
            osc1_enable_nxt = 1'b1;
            cnt_nxt         = '0;
            stab_nxt        = '0;
          end
`else
          state_nxt       = START1;
          osc1_enable_nxt = 1'b1;
          cnt_nxt         = '0;
          stab_nxt        = '0;
`endif
        end
      end

      START1: begin
        cnt_nxt  = cnt_inc;
        stab_nxt = osc1_ok_sync ? stab_inc : '0;
        // The stability check has priority: a switch that qualifies on the
        // last budget cycle still goes ahead.
        if (osc1_ok_sync && (stab_inc == STAB_LIM)) begin
          state_nxt     = SWITCH1;
          selection_nxt = 1'b1;
          cnt_nxt       = '0;
          stab_nxt      = '0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          fault_set = 1'b1;
          state_nxt = STOP1;
          cnt_nxt   = '0;
        end else if (!sel_req) begin
          state_nxt = STOP1;
          cnt_nxt   = '0;
        end
      end

      SWITCH1: begin
        cnt_nxt = cnt_inc;
        // Losing the oscillator mid-handover overrides the hold time.
        // The new source is gone, so the mux cannot finish switching to it.
        if (!osc1_ok_sync) begin
          fault_set     = 1'b1;
          state_nxt     = SWITCH0;
          selection_nxt = 1'b0;
          cnt_nxt       = '0;
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
          loss_exit_nxt = 1'b1;
`endif
        end else if (cnt_inc == SWITCH_LIM) begin
          state_nxt      = ON1;
          sel_status_nxt = 1'b1;
          cnt_nxt        = '0;
        end
      end

      ON1: begin
        if (!osc1_ok_sync) begin
          fault_set      = 1'b1;
          state_nxt      = SWITCH0;
          selection_nxt  = 1'b0;
          sel_status_nxt = 1'b0;
          cnt_nxt        = '0;
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
          loss_exit_nxt  = 1'b1;
`endif
        end else if (!sel_req) begin
          state_nxt      = SWITCH0;
          selection_nxt  = 1'b0;
          sel_status_nxt = 1'b0;
          cnt_nxt        = '0;
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
          loss_exit_nxt  = 1'b0;
`endif
        end
      end

      SWITCH0: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == SWITCH_LIM) begin
          cnt_nxt = '0;
`ifdef MSP430_CLKSW_OSC_KEEPALIVE_EN
          state_nxt = loss_exit ? STOP1 : IDLE0;
`else
          state_nxt = STOP1;
`endif
        end
      end

      STOP1: begin
        osc1_enable_nxt = 1'b0;
        state_nxt       = IDLE0;
        cnt_nxt         = '0;
      end

      default: begin
        state_nxt       = IDLE0;
        cnt_nxt         = '0;
        stab_nxt        = '0;
        selection_nxt   = 1'b0;
        osc1_enable_nxt = 1'b0;
        sel_status_nxt  = 1'b0;
      end
    endcase

    // A new detection wins over a clear pulse in the same cycle.
    fault_nxt = fault_set | (fault & ~fault_clr);
    busy_nxt  = !((state_nxt == IDLE0) || (state_nxt == ON1));
  end

endmodule
